// File: rtl/lcd_pkg.sv
// lcd_pkg: shared opcodes, sequencer FSM encoding and opcode legality helper.
package lcd_pkg;
  localparam logic [3:0] CMD_WRITE = 4'h0;
  localparam logic [3:0] CMD_LOAD  = 4'hC;
  localparam logic [3:0] CMD_MAX   = 4'hC;
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_GUARD     = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;
  function automatic logic is_legal(input logic [3:0] c);
    return c <= CMD_MAX;
  endfunction
endpackage

// File: rtl/lcd_cmd_sequencer_if.sv
// lcd_cmd_sequencer_if: host push handshake plus controller issue/busy/done signals.
interface lcd_cmd_sequencer_if;
  logic [3:0] host_cmd;
  logic       host_valid;
  logic       host_ready;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       busy;
  logic       done;
  logic       seq_done;
  modport master (output host_cmd, host_valid, busy, done, input host_ready, cmd, cmd_valid, seq_done);
  modport slave  (input host_cmd, host_valid, busy, done, output host_ready, cmd, cmd_valid, seq_done);
endinterface

// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo: DEPTH x 4 opcode FIFO; refuses push when full, ignores pop when empty.
module lcd_cmd_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [3:0]               din_i,
  output logic [3:0]               dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;
  // occupancy never exceeds 2^AW, so the top count bit alone marks full
  assign full_o  = cnt_q[AW];
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rp_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end
endmodule

// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: queues host opcodes and issues them to the LCD controller when it is idle.
module lcd_cmd_sequencer import lcd_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  lcd_cmd_sequencer_if.slave     bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]       illegal_cnt
);
  logic [1:0]       st_q, st_d;
  logic [3:0]       cmd_q, cmd_d, head;
  logic             vld_q, vld_d, sd_q, sd_d, rdy_q;
  logic [CNT_W-1:0] ill_q;
  logic             full, empty, pop, accept, push;
  assign accept          = bus.host_valid & bus.host_ready;
  assign push            = accept & is_legal(bus.host_cmd);
  assign bus.host_ready  = rdy_q & ~full;
  assign bus.cmd         = cmd_q;
  assign bus.cmd_valid   = vld_q;
  assign bus.seq_done    = sd_q;
  assign illegal_cnt     = ill_q;
  lcd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push_i(push), .pop_i(pop), .din_i(bus.host_cmd),
    .dout_o(head), .full_o(full), .empty_o(empty), .count_o(fifo_count)
  );
  always_comb begin
    st_d  = st_q;
    cmd_d = cmd_q;
    vld_d = 1'b0;
    sd_d  = 1'b0;
    pop   = 1'b0;
    case (st_q)
      S_IDLE: if (!empty && !bus.busy) begin
        pop   = 1'b1;
        cmd_d = head;
        vld_d = 1'b1;
        st_d  = S_ISSUE;
      end
      S_ISSUE: st_d = (cmd_q == CMD_WRITE) ? S_WAIT_DONE : S_GUARD;
      S_GUARD: st_d = S_IDLE;
      default: if (bus.done) begin
        sd_d = 1'b1;
        st_d = S_GUARD;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q  <= S_IDLE;
      cmd_q <= '0;
      vld_q <= 1'b0;
      sd_q  <= 1'b0;
      rdy_q <= 1'b0;
      ill_q <= '0;
    end else begin
      st_q  <= st_d;
      cmd_q <= cmd_d;
      vld_q <= vld_d;
      sd_q  <= sd_d;
      rdy_q <= 1'b1;
      if (accept && !is_legal(bus.host_cmd) && !(&ill_q)) ill_q <= ill_q + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb_lcd_cmd_sequencer: scoreboard bench with directed scenarios and randomized bursts.
module tb_lcd_cmd_sequencer;
  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
  logic clk = 0, reset = 1;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [CNT_W-1:0] illegal_cnt;
  lcd_cmd_sequencer_if bus();
  lcd_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus), .fifo_count(fifo_count), .illegal_cnt(illegal_cnt)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  int checks = 0, errors = 0;
  logic [3:0] exp_q[$];
  int issue_q[$];
  int seq_cyc = -1, done_cyc = -1, ill_m = 0, done_dly = 3;
  logic done_prev = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", n, a, e, cyc);
    end
  endtask

  // scoreboard monitor: every issue strobe must match the oldest accepted legal opcode
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.cmd_valid) begin
        issue_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: got cmd %0h expected no issue at cycle %0d", bus.cmd, cyc);
        end else chk("issue_cmd", 32'(bus.cmd), 32'(exp_q.pop_front()));
      end
      if (bus.seq_done) begin
        seq_cyc = cyc;
        chk("seq_done_follows_done", 32'(done_prev), 1);
      end
      if (bus.done) done_cyc = cyc;
      done_prev = bus.done;
    end
  end

  // controller model: answers each Write with a one-cycle done after done_dly cycles
  initial begin
    bus.done = 0;
    forever begin
      @(negedge clk);
      if (!reset && bus.cmd_valid && bus.cmd == 4'h0) begin
        repeat (done_dly) @(posedge clk);
        #1 bus.done = 1;
        @(posedge clk);
        #1 bus.done = 0;
      end
    end
  end

  task automatic push(input logic [3:0] c, input bit exp_acc);
    chk("host_ready", 32'(bus.host_ready), 32'(exp_acc));
    bus.host_cmd = c;
    bus.host_valid = 1;
    @(posedge clk);
    #1 bus.host_valid = 0;
    if (exp_acc) begin
      if (c <= 4'hC) exp_q.push_back(c);
      else ill_m = (ill_m < 255) ? ill_m + 1 : 255;
    end
  endtask

  task automatic wait_issues(input int n);
    int b = 0;
    while (issue_q.size() < n && b < 500) begin
      @(posedge clk);
      b++;
    end
    #1;
    if (issue_q.size() < n) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got %0d issues required %0d", issue_q.size(), n);
    end
  endtask

  task automatic drain(input bit rand_busy);
    int b = 0;
    while (exp_q.size() != 0 && b < 2000) begin
      @(posedge clk);
      #1 if (rand_busy) bus.busy = 1'($urandom_range(0, 1));
      b++;
    end
    bus.busy = 0;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
    end
    repeat (done_dly + 6) @(posedge clk);
    #1;
  endtask

  initial begin
    int base, vc, occ, n;
    logic [3:0] c;
    bus.host_cmd = 0;
    bus.host_valid = 0;
    bus.busy = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_host_ready", 32'(bus.host_ready), 0);
    chk("rst_cmd_valid", 32'(bus.cmd_valid), 0);
    chk("rst_cmd", 32'(bus.cmd), 0);
    chk("rst_seq_done", 32'(bus.seq_done), 0);
    chk("rst_fifo_count", 32'(fifo_count), 0);
    chk("rst_illegal_cnt", 32'(illegal_cnt), 0);
    reset = 0;
    @(posedge clk);
    #1 chk("ready_after_rst", 32'(bus.host_ready), 1);
    // single push into an empty FIFO with busy low
    base = issue_q.size();
    vc = cyc;
    push(4'h1, 1);
    wait_issues(base + 1);
    chk("push_to_issue_latency", 32'(issue_q[base] - vc), 2);
    chk("strobe_one_cycle", 32'(bus.cmd_valid), 0);
    drain(0);
    // fill while busy, refuse the ninth, then drain at minimum spacing
    bus.busy = 1;
    for (int i = 1; i <= 8; i++) push(4'(i), 1);
    chk("full_count", 32'(fifo_count), DEPTH);
    push(4'h9, 0);
    chk("refused_count", 32'(fifo_count), DEPTH);
    base = issue_q.size();
    bus.busy = 0;
    wait_issues(base + 8);
    for (int i = 1; i < 8; i++) chk("issue_spacing", 32'(issue_q[base + i] - issue_q[base + i - 1]), 3);
    drain(0);
    // illegal opcodes are dropped and counted, saturating
    base = issue_q.size();
    push(4'hE, 1);
    push(4'hF, 1);
    push(4'hD, 1);
    chk("illegal_count3", 32'(illegal_cnt), 3);
    chk("illegal_not_queued", 32'(fifo_count), 0);
    for (int i = 0; i < 252; i++) push(4'($urandom_range(13, 15)), 1);
    chk("illegal_at_max", 32'(illegal_cnt), 255);
    push(4'hE, 1);
    chk("illegal_saturated", 32'(illegal_cnt), 32'(ill_m));
    repeat (4) @(posedge clk);
    #1 chk("illegal_no_issue", 32'(issue_q.size()), 32'(base));
    // Write stalls the next opcode until done
    done_dly = 10;
    base = issue_q.size();
    push(4'h0, 1);
    push(4'h5, 1);
    wait_issues(base + 2);
    chk("done_delay", 32'(done_cyc - issue_q[base]), 10);
    chk("seq_after_done", 32'(seq_cyc - done_cyc), 1);
    chk("issue_after_seq", 32'(issue_q[base + 1] - seq_cyc), 2);
    drain(0);
    // full FIFO: push refused while the pop lands
    done_dly = 3;
    bus.busy = 1;
    for (int i = 0; i < DEPTH; i++) push(4'($urandom_range(1, 12)), 1);
    chk("full_ready_low", 32'(bus.host_ready), 0);
    bus.busy = 0;
    bus.host_cmd = 4'h3;
    bus.host_valid = 1;
    @(posedge clk);
    #1 bus.host_valid = 0;
    chk("push_pop_full_count", 32'(fifo_count), DEPTH - 1);
    chk("ready_after_pop", 32'(bus.host_ready), 1);
    drain(0);
    // reset while in ISSUE with entries queued
    bus.busy = 1;
    for (int i = 2; i <= 6; i++) push(4'(i), 1);
    bus.busy = 0;
    n = 0;
    while (!bus.cmd_valid && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    chk("reached_issue", 32'(bus.cmd_valid), 1);
    chk("queued_at_issue", 32'(fifo_count), 4);
    reset = 1;
    #1;
    chk("async_rst_cmd_valid", 32'(bus.cmd_valid), 0);
    chk("async_rst_count", 32'(fifo_count), 0);
    chk("async_rst_illegal", 32'(illegal_cnt), 0);
    exp_q.delete();
    ill_m = 0;
    @(posedge clk);
    #1 reset = 0;
    base = issue_q.size();
    repeat (20) @(posedge clk);
    #1 chk("no_issue_after_rst", 32'(issue_q.size()), 32'(base));
    push(4'h7, 1);
    drain(0);
    // randomized bursts against the queue model
    for (int r = 0; r < 8; r++) begin
      bus.busy = 1;
      occ = 0;
      n = $urandom_range(0, DEPTH + 3);
      for (int i = 0; i < n; i++) begin
        c = 4'($urandom_range(0, 15));
        push(c, occ < DEPTH);
        if (occ < DEPTH && c <= 4'hC) occ++;
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
      chk("burst_count", 32'(fifo_count), 32'(occ));
      done_dly = $urandom_range(1, 6);
      drain(1);
      chk("burst_illegal", 32'(illegal_cnt), 32'(ill_m));
      chk("burst_empty", 32'(fifo_count), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
